// File: rtl/ifu_litebpu.sv
// Lite branch-prediction unit: static taken/not-taken prediction, target adder
// operands, and JALR rs1 base resolution with a one-cycle borrowed rs1 read port.
module ifu_litebpu #(
    parameter int PC_SIZE     = 32,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_SIZE-1:0]     pc,
    input  logic                   dec_i_valid,
    input  logic                   dec_jal,
    input  logic                   dec_jalr,
    input  logic                   dec_bxx,
    input  logic [XLEN-1:0]        dec_bjp_imm,
    input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
    input  logic                   oitf_empty,
    input  logic                   ir_empty,
    input  logic                   ir_rs1en,
    input  logic                   ir_valid_clr,
    input  logic                   jalr_rs1idx_cam_irrdidx,
    input  logic [XLEN-1:0]        rf2bpu_x1,
    input  logic [XLEN-1:0]        rf2bpu_rs1,
    output logic                   prdt_taken,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
    output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
    output logic                   bpu_wait,
    output logic                   bpu2rf_rs1_ena
);

    typedef enum logic {
        IDLE = 1'b0,
        RDRF = 1'b1
    } rdrf_state_e;

    rdrf_state_e rdrf_r;
    rdrf_state_e w_rdrf_nxt;

    logic w_rs1_x0;
    logic w_rs1_x1;
    logic w_rs1_xn;
    logic w_jalr_vld;
    logic w_dep_x1;
    logic w_dep_xn;
    logic w_dep_xn_clr;
    logic w_rdrf_set;

    assign w_rs1_x0   = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
    assign w_rs1_x1   = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
    assign w_rs1_xn   = ~w_rs1_x0 & ~w_rs1_x1;
    assign w_jalr_vld = dec_i_valid & dec_jalr;

    // x1 is stale while a long op is outstanding or the IR instruction writes it.
    assign w_dep_x1     = w_jalr_vld & w_rs1_x1 & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign w_dep_xn     = w_jalr_vld & w_rs1_xn & (~oitf_empty | ~ir_empty);
    // The IR instruction is leaving or never uses the rs1 port, so it can be claimed now.
    assign w_dep_xn_clr = w_dep_xn & oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);

    assign w_rdrf_set = (rdrf_r == IDLE) & w_jalr_vld & w_rs1_xn & (~w_dep_xn | w_dep_xn_clr);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_rdrf_nxt = IDLE;
        if ((rdrf_r == IDLE) && w_rdrf_set) begin
            w_rdrf_nxt = RDRF;
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdrf_r <= IDLE;
        end else begin
            rdrf_r <= w_rdrf_nxt;
        end
    end

    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]);

    assign prdt_pc_add_op2 = PC_SIZE'($signed(dec_bjp_imm));

    always_comb begin
        prdt_pc_add_op1 = pc;
        if (dec_jalr) begin
            if (w_rs1_x0) begin
                prdt_pc_add_op1 = '0;
            end else if (w_rs1_x1) begin
                prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
            end else begin
                prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
            end
        end
    end

    assign bpu2rf_rs1_ena = w_rdrf_set;
    assign bpu_wait       = w_dep_x1 | w_dep_xn | w_rdrf_set;

endmodule

// File: tb/tb_ifu_litebpu.sv
// Self-checking bench for ifu_litebpu: directed test-plan steps followed by
// randomized cycles compared against a behavioural prediction model.
module tb_ifu_litebpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic        oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        prdt_taken, bpu_wait, bpu2rf_rs1_ena;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

    int n_vec = 0;
    int n_err = 0;

    // model state: a port read was issued in the previous cycle
    bit          m_reading;
    bit          e_taken, e_wait, e_ena;
    logic [31:0] e_op1, e_op2;

    ifu_litebpu dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pc                      (pc),
        .dec_i_valid             (dec_i_valid),
        .dec_jal                 (dec_jal),
        .dec_jalr                (dec_jalr),
        .dec_bxx                 (dec_bxx),
        .dec_bjp_imm             (dec_bjp_imm),
        .dec_jalr_rs1idx         (dec_jalr_rs1idx),
        .oitf_empty              (oitf_empty),
        .ir_empty                (ir_empty),
        .ir_rs1en                (ir_rs1en),
        .ir_valid_clr            (ir_valid_clr),
        .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx),
        .rf2bpu_x1               (rf2bpu_x1),
        .rf2bpu_rs1              (rf2bpu_rs1),
        .prdt_taken              (prdt_taken),
        .prdt_pc_add_op1         (prdt_pc_add_op1),
        .prdt_pc_add_op2         (prdt_pc_add_op2),
        .bpu_wait                (bpu_wait),
        .bpu2rf_rs1_ena          (bpu2rf_rs1_ena)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference derived from the prediction and hazard rules.
    task automatic model();
        bit is_jalr_req, base_x1, base_xn;
        bit x1_stale, xn_busy, may_grab;
        e_taken = dec_jal || dec_jalr || (dec_bxx && $signed(dec_bjp_imm) < 0);
        e_op2   = dec_bjp_imm;
        case (dec_jalr_rs1idx)
            5'd0:    begin base_x1 = 0; base_xn = 0; end
            5'd1:    begin base_x1 = 1; base_xn = 0; end
            default: begin base_x1 = 0; base_xn = 1; end
        endcase
        if (!dec_jalr)         e_op1 = pc;
        else if (base_x1)      e_op1 = rf2bpu_x1;
        else if (base_xn)      e_op1 = rf2bpu_rs1;
        else                   e_op1 = 32'h0;
        is_jalr_req = dec_i_valid && dec_jalr;
        x1_stale = !oitf_empty || jalr_rs1idx_cam_irrdidx;
        xn_busy  = !oitf_empty || !ir_empty;
        may_grab = oitf_empty && !ir_empty && (ir_valid_clr || !ir_rs1en);
        e_ena  = is_jalr_req && base_xn && !m_reading && (!xn_busy || may_grab);
        e_wait = (is_jalr_req && base_x1 && x1_stale) ||
                 (is_jalr_req && base_xn && xn_busy) || e_ena;
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        model();
        check({tag, ".taken"}, 32'(prdt_taken), 32'(e_taken));
        check({tag, ".op1"},   prdt_pc_add_op1, e_op1);
        check({tag, ".op2"},   prdt_pc_add_op2, e_op2);
        check({tag, ".wait"},  32'(bpu_wait),   32'(e_wait));
        check({tag, ".ena"},   32'(bpu2rf_rs1_ena), 32'(e_ena));
        check({tag, ".rdrf"},  32'(dut.rdrf_r), 32'(m_reading));
    endtask

    task automatic advance();
        @(posedge clk);
        m_reading = rst_n ? e_ena : 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        pc = '0; dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        dec_bjp_imm = '0; dec_jalr_rs1idx = '0; oitf_empty = 0; ir_empty = 0;
        ir_rs1en = 0; ir_valid_clr = 0; jalr_rs1idx_cam_irrdidx = 0;
        rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
    endtask

    task automatic jalr_req(input logic [4:0] idx, input logic [31:0] imm);
        dec_i_valid = 1; dec_jal = 0; dec_bxx = 0; dec_jalr = 1;
        dec_jalr_rs1idx = idx; dec_bjp_imm = imm;
    endtask

    initial begin
        int waits;
        int pick;
        idle_inputs();
        rst_n = 0;
        m_reading = 0;
        #12;
        check("reset.rdrf",  32'(dut.rdrf_r), 32'h0);
        check("reset.taken", 32'(prdt_taken), 32'h0);
        check("reset.op1",   prdt_pc_add_op1, 32'h0);
        check("reset.op2",   prdt_pc_add_op2, 32'h0);
        check("reset.wait",  32'(bpu_wait), 32'h0);
        check("reset.ena",   32'(bpu2rf_rs1_ena), 32'h0);
        @(negedge clk);
        rst_n = 1;
        advance();

        // backward branch predicted taken
        oitf_empty = 1; ir_empty = 1;
        dec_i_valid = 1; dec_bxx = 1; pc = 32'h100; dec_bjp_imm = 32'hFFFF_FFF0;
        sample("bxx_back");
        check("bxx_back.taken_c", 32'(prdt_taken), 32'h1);
        check("bxx_back.op1_c",   prdt_pc_add_op1, 32'h100);
        check("bxx_back.op2_c",   prdt_pc_add_op2, 32'hFFFF_FFF0);
        check("bxx_back.wait_c",  32'(bpu_wait), 32'h0);
        advance();

        dec_bjp_imm = 32'h20;
        sample("bxx_fwd");
        check("bxx_fwd.taken_c", 32'(prdt_taken), 32'h0);
        check("bxx_fwd.op2_c",   prdt_pc_add_op2, 32'h20);
        advance();

        dec_bxx = 0; dec_jal = 1; pc = 32'h444;
        sample("jal");
        check("jal.taken_c", 32'(prdt_taken), 32'h1);
        check("jal.op1_c",   prdt_pc_add_op1, 32'h444);
        advance();

        jalr_req(5'd0, 32'h80);
        sample("jalr_x0");
        check("jalr_x0.op1_c",  prdt_pc_add_op1, 32'h0);
        check("jalr_x0.op2_c",  prdt_pc_add_op2, 32'h80);
        check("jalr_x0.wait_c", 32'(bpu_wait), 32'h0);
        advance();

        // x1 base held off by an outstanding long-latency op
        jalr_req(5'd1, 32'h4);
        rf2bpu_x1 = 32'h2000; oitf_empty = 0;
        waits = 0;
        for (int i = 0; i < 3; i++) begin
            sample("jalr_x1_dep");
            if (bpu_wait) waits++;
            advance();
        end
        oitf_empty = 1;
        sample("jalr_x1_go");
        if (bpu_wait) waits++;
        check("jalr_x1.op1_c",      prdt_pc_add_op1, 32'h2000);
        check("jalr_x1.wait_cycles", 32'(waits), 32'd3);
        advance();

        // xn base via the borrowed rs1 read port
        jalr_req(5'd5, 32'h10);
        oitf_empty = 1; ir_empty = 1;
        sample("jalr_x5_n");
        check("jalr_x5_n.ena_c",  32'(bpu2rf_rs1_ena), 32'h1);
        check("jalr_x5_n.wait_c", 32'(bpu_wait), 32'h1);
        advance();
        rf2bpu_rs1 = 32'h3000;
        sample("jalr_x5_n1");
        check("jalr_x5_n1.op1_c",  prdt_pc_add_op1, 32'h3000);
        check("jalr_x5_n1.wait_c", 32'(bpu_wait), 32'h0);
        check("jalr_x5_n1.ena_c",  32'(bpu2rf_rs1_ena), 32'h0);
        advance();
        dec_i_valid = 0; dec_jalr = 0;
        sample("gap");
        advance();

        // xn blocked by an IR instruction owning the rs1 port, released on dispatch
        jalr_req(5'd5, 32'h10);
        ir_empty = 0; ir_rs1en = 1; ir_valid_clr = 0;
        for (int i = 0; i < 2; i++) begin
            sample("jalr_x5_blk");
            check("jalr_x5_blk.ena_c", 32'(bpu2rf_rs1_ena), 32'h0);
            advance();
        end
        ir_valid_clr = 1;
        sample("jalr_x5_clr");
        check("jalr_x5_clr.ena_c", 32'(bpu2rf_rs1_ena), 32'h1);
        advance();
        rst_n = 0; dec_i_valid = 0;
        #1;
        m_reading = 0;
        check("midread_rst.rdrf", 32'(dut.rdrf_r), 32'h0);
        check("midread_rst.ena",  32'(bpu2rf_rs1_ena), 32'h0);
        sample("in_rst");
        rst_n = 1;
        advance();

        // flush while the read is in flight
        idle_inputs();
        oitf_empty = 1; ir_empty = 1;
        jalr_req(5'd7, 32'h0);
        sample("flush_set");
        advance();
        dec_i_valid = 0;
        sample("flush_rdrf");
        advance();
        sample("flush_idle");
        advance();

        for (int n = 0; n < 600; n++) begin
            pc          = $urandom;
            dec_bjp_imm = $urandom;
            rf2bpu_x1   = $urandom;
            rf2bpu_rs1  = $urandom;
            dec_i_valid = ($urandom_range(0, 9) != 0);
            pick        = $urandom_range(0, 3);
            dec_jal     = (pick == 1);
            dec_jalr    = (pick == 2);
            dec_bxx     = (pick == 3);
            dec_jalr_rs1idx = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 2))
                                                         : 5'($urandom);
            oitf_empty  = ($urandom_range(0, 3) != 0);
            ir_empty    = $urandom_range(0, 1) != 0;
            ir_rs1en    = $urandom_range(0, 1) != 0;
            ir_valid_clr = $urandom_range(0, 1) != 0;
            jalr_rs1idx_cam_irrdidx = ($urandom_range(0, 3) == 0);
            sample("rand");
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
